// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//
// Shared I2C definitions for the slave receive/transmit frame blocks.
//   - i2c_rf_state_e : state encoding of the receive-frame FSM
//                      (I2C_RF_IDLE, I2C_RF_DATA, I2C_RF_ACK)
//   - I2C_ACK        : bus level that acknowledges a word (low)
//   - I2C_NACK       : bus level of a released / not-acknowledged line (high)
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [1:0] {
        I2C_RF_IDLE = 2'd0,
        I2C_RF_DATA = 2'd1,
        I2C_RF_ACK  = 2'd2
    } i2c_rf_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_edge_detect.sv
// ---------------------------------------------------------------------------
// i2c_bus_edge_detect
//
// Registers the previous SCL/SDA levels and derives bus events from them.
// Shared by the receive-frame block and the future transmit-frame block.
//
// Ports
//   clock      in  system clock
//   reset_n    in  asynchronous active-low reset
//   scl        in  bus clock, already synchronised
//   sda        in  bus data, already synchronised
//   rise       out SCL rising edge this cycle
//   fall       out SCL falling edge this cycle
//   violation  out SDA changed while SCL stayed high (START or STOP)
// ---------------------------------------------------------------------------
module i2c_bus_edge_detect
    import i2c_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic rise,
    output logic fall,
    output logic violation
);

    logic scl_last_d, scl_last_q;
    logic sda_last_d, sda_last_q;

    always_comb begin
        scl_last_d = scl;
        sda_last_d = sda;
    end

    // Both lines reset to the released (high) level so that a bus sitting
    // idle at reset release produces no spurious edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_last_q <= 1'b1;
            sda_last_q <= I2C_NACK;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples pre-edge values regardless of statement order.
            scl_last_q <= scl_last_d;
            sda_last_q <= sda_last_d;
        end
    end

    assign rise      = ~scl_last_q & scl;
    assign fall      =  scl_last_q & ~scl;
    // SCL high on both samples rules out a rise, so a rise and a violation
    // can never coincide.
    assign violation =  scl_last_q & scl & (sda ^ sda_last_q);

endmodule

// File: rtl/i2c_slave_read_frame.sv
// ---------------------------------------------------------------------------
// i2c_slave_read_frame
//
// Multi-word I2C slave receiver. Samples SDA on SCL rising edges, assembles
// BYTE_COUNT words of DATA_WIDTH bits MSB-first, consumes the ACK clock after
// every word and flags START/STOP conditions seen inside a frame.
//
// Configuration macro
//   I2C_SLAVE_READ_ACK_EN  defined: sda_low is driven high during every ACK
//                          slot. Undefined: sda_low stays 0 and the ACK is
//                          left to an external driver (slot timing unchanged).
//
// Parameters
//   DATA_WIDTH  bits per word (>= 1)
//   BYTE_COUNT  words per frame (>= 1)
//
// Ports
//   clock       in  system clock
//   reset_n     in  asynchronous active-low reset
//   enable      in  frame start, pulse coincident with the first SCL rise
//   scl, sda    in  synchronised bus lines
//   sda_low     out pull SDA low (ACK)
//   data_out    out received words, word 0 in the top slice
//   byte_valid  out one-cycle pulse when a word lands in data_out
//   byte_index  out index of the word just completed (valid with byte_valid)
//   finish      out one-cycle pulse at the end of the frame
//   error       out sticky protocol-violation flag, cleared by a new frame
// ---------------------------------------------------------------------------
module i2c_slave_read_frame
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_COUNT = 2
) (
    input  logic                                              clock,
    input  logic                                              reset_n,
    input  logic                                              enable,
    input  logic                                              scl,
    input  logic                                              sda,
    output logic                                              sda_low,
    output logic [BYTE_COUNT*DATA_WIDTH-1:0]                  data_out,
    output logic                                              byte_valid,
    output logic [((BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1)-1:0] byte_index,
    output logic                                              finish,
    output logic                                              error
);

    localparam int IDX_W   = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
    localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int FRAME_W = BYTE_COUNT * DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_WORD = CNT_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BYTE_COUNT - 1);

`ifdef I2C_SLAVE_READ_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus events
    // ------------------------------------------------------------------
    logic rise;
    logic fall;
    logic violation;

    i2c_bus_edge_detect u_edge (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda       (sda),
        .rise      (rise),
        .fall      (fall),
        .violation (violation)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2c_rf_state_e          state_d,      state_q;
    logic [CNT_W-1:0]       bit_cnt_d,    bit_cnt_q;
    logic [IDX_W-1:0]       byte_cnt_d,   byte_cnt_q;
    logic [DATA_WIDTH-1:0]  shift_d,      shift_q;
    logic [FRAME_W-1:0]     data_out_d,   data_out_q;
    logic                   byte_valid_d, byte_valid_q;
    logic [IDX_W-1:0]       byte_index_d, byte_index_q;
    logic                   finish_d,     finish_q;
    logic                   error_d,      error_q;
    logic                   sda_low_d,    sda_low_q;
    logic                   word_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        byte_valid_d = 1'b0;
        byte_index_d = byte_index_q;
        finish_d     = 1'b0;
        error_d      = error_q;
        word_done    = 1'b0;

        case (state_q)
            I2C_RF_IDLE: begin
                // The enable cycle is itself the first SCL rise, so its SDA
                // sample is the first (most significant) bit of word 0.
                if (enable && scl) begin
                    shift_d    = DATA_WIDTH'(sda);
                    bit_cnt_d  = CNT_W'(1);
                    byte_cnt_d = '0;
                    error_d    = 1'b0;
                    state_d    = I2C_RF_DATA;
                    word_done  = (DATA_WIDTH == 1);
                end
            end

            I2C_RF_DATA: begin
                if (rise) begin
                    shift_d   = (shift_q << 1) | DATA_WIDTH'(sda);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    word_done = (bit_cnt_d == FULL_WORD);
                end else if (fall && (bit_cnt_q == FULL_WORD)) begin
                    // SCL drops after the last data bit: the 9th clock begins.
                    state_d = I2C_RF_ACK;
                end
            end

            I2C_RF_ACK: begin
                // The fall that entered ACK was consumed in DATA, so the first
                // fall seen here is the one that closes the 9th clock.
                if (fall) begin
                    if (byte_cnt_q == LAST_WORD) begin
                        finish_d = 1'b1;
                        state_d  = I2C_RF_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + IDX_W'(1);
                        bit_cnt_d  = '0;
                        state_d    = I2C_RF_DATA;
                    end
                end
            end

            default: state_d = I2C_RF_IDLE;
        endcase

        // START/STOP inside a frame abandons the partial word; slices already
        // written stay as they are.
        if ((state_q != I2C_RF_IDLE) && violation) begin
            state_d   = I2C_RF_IDLE;
            error_d   = 1'b1;
            word_done = 1'b0;
            finish_d  = 1'b0;
        end

        // Completed word goes straight into its slice on the same edge that
        // raises byte_valid, so data_out is already current during the pulse.
        if (word_done) begin
            byte_valid_d = 1'b1;
            byte_index_d = byte_cnt_d;
            for (int w = 0; w < BYTE_COUNT; w++) begin
                if (w == (BYTE_COUNT - 1 - int'(byte_cnt_d))) begin
                    data_out_d[w*DATA_WIDTH +: DATA_WIDTH] = shift_d;
                end
            end
        end

        // Pulling the line low expresses an ACK because the ACK level is low.
        sda_low_d = ACK_EN && (I2C_ACK == 1'b0) && (state_d == I2C_RF_ACK);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= I2C_RF_IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            // NOTE: the word store is reset along with the control flops
            // because its reset value is part of the visible interface.
            data_out_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_index_q <= '0;
            finish_q     <= 1'b0;
            error_q      <= 1'b0;
            sda_low_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            byte_valid_q <= byte_valid_d;
            byte_index_q <= byte_index_d;
            finish_q     <= finish_d;
            error_q      <= error_d;
            sda_low_q    <= sda_low_d;
        end
    end

    assign sda_low    = sda_low_q;
    assign data_out   = data_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_index = byte_index_q;
    assign finish     = finish_q;
    assign error      = error_q;

endmodule

// File: tb/tb_i2c_slave_read_frame.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_read_frame
//
// Bench for i2c_slave_read_frame. The bus driver works at bit/word/frame
// level; as it produces each bus event it updates a frame-level model of the
// outputs (words stored by slot, error flag, ACK drive, pulses) which one
// process compares against the DUT on every falling clock edge. A second
// instance (DATA_WIDTH=1, BYTE_COUNT=1) is checked with literal expectations.
// ---------------------------------------------------------------------------
module tb_i2c_slave_read_frame;
    import i2c_pkg::*;

    localparam int DW = 8;
    localparam int BC = 2;
    localparam int FW = DW * BC;

`ifdef I2C_SLAVE_READ_ACK_EN
    localparam logic ACK_ON = 1'b1;
`else
    localparam logic ACK_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    logic enable, scl, sda;
    logic sda_low, byte_valid, finish, error;
    logic [FW-1:0] data_out;
    logic [0:0] byte_index;

    logic en_b, scl_b, sda_b;
    logic sda_low_b, byte_valid_b, finish_b, error_b;
    logic [0:0] data_out_b;
    logic [0:0] byte_index_b;

    always #5 clock = ~clock;

    i2c_slave_read_frame #(.DATA_WIDTH(DW), .BYTE_COUNT(BC)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .scl(scl), .sda(sda),
        .sda_low(sda_low), .data_out(data_out), .byte_valid(byte_valid),
        .byte_index(byte_index), .finish(finish), .error(error)
    );

    i2c_slave_read_frame #(.DATA_WIDTH(1), .BYTE_COUNT(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(en_b), .scl(scl_b), .sda(sda_b),
        .sda_low(sda_low_b), .data_out(data_out_b), .byte_valid(byte_valid_b),
        .byte_index(byte_index_b), .finish(finish_b), .error(error_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model
    // ------------------------------------------------------------------
    typedef enum {FA_NONE, FA_ENTER_ACK, FA_LEAVE_MORE, FA_LEAVE_LAST} fall_act_e;

    logic [FW-1:0] m_data;
    logic          m_err, m_sda_low, m_bv, m_fin;
    int            m_idx;
    fall_act_e     fall_act;
    bit            cmp_on = 0;
    int            bv_idx_q[$];
    int            fin_count;

    always @(negedge clock) begin
        if (cmp_on) begin
            check("data_out", data_out, m_data);
            check("byte_valid", byte_valid, m_bv);
            if (m_bv) check("byte_index", byte_index, m_idx);
            check("finish", finish, m_fin);
            check("error", error, m_err);
            check("sda_low", sda_low, m_sda_low);
            if (byte_valid) bv_idx_q.push_back(int'(byte_index));
            if (finish) fin_count++;
        end
    end

    // One system clock with the given bus levels; returns just after the edge.
    task automatic cyc(input logic s_scl, input logic s_sda, input logic s_en);
        scl = s_scl; sda = s_sda; enable = s_en;
        @(posedge clock); #1;
        m_bv = 1'b0; m_fin = 1'b0;
    endtask

    // First SCL-low cycle: the fall happens here, apply what it means.
    task automatic low_first(input logic b);
        cyc(1'b0, b, 1'b0);
        case (fall_act)
            FA_ENTER_ACK:  m_sda_low = ACK_ON;
            FA_LEAVE_MORE: m_sda_low = 1'b0;
            FA_LEAVE_LAST: begin m_sda_low = 1'b0; m_fin = 1'b1; end
            default: ;
        endcase
        fall_act = FA_NONE;
    endtask

    // One SCL period: 2 clocks low, 2 clocks high.
    task automatic bit_slot(input logic b, input logic start, input logic stray_en,
                            input logic last, input int w, input logic [DW-1:0] word);
        low_first(b);
        cyc(1'b0, b, 1'b0);
        cyc(1'b1, b, start | stray_en);
        if (start) m_err = 1'b0;
        if (last) begin
            m_bv  = 1'b1;
            m_idx = w;
            m_data[(BC-1-w)*DW +: DW] = word;
        end
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic send_word(input int w, input logic [DW-1:0] val, input logic start,
                             input int stray_bit);
        for (int i = DW-1; i >= 0; i--)
            bit_slot(val[i], start && (i == DW-1), i == stray_bit, i == 0, w, val);
        fall_act = FA_ENTER_ACK;
        bit_slot(I2C_ACK, 1'b0, 1'b0, 1'b0, w, val);
        fall_act = (w == BC-1) ? FA_LEAVE_LAST : FA_LEAVE_MORE;
    endtask

    task automatic bus_end();
        low_first(I2C_NACK);
        cyc(1'b0, I2C_NACK, 1'b0);
        cyc(1'b1, I2C_NACK, 1'b0);
        cyc(1'b1, I2C_NACK, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input int stray_bit);
        send_word(0, w0, 1'b1, stray_bit);
        send_word(1, w1, 1'b0, -1);
        bus_end();
    endtask

    task automatic cycb(input logic s_scl, input logic s_sda, input logic s_en);
        scl_b = s_scl; sda_b = s_sda; en_b = s_en;
        @(posedge clock); #1;
        m_bv = 1'b0; m_fin = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        m_data = '0; m_err = 0; m_sda_low = 0; m_bv = 0; m_fin = 0; m_idx = 0;
        fall_act = FA_NONE; fin_count = 0;
        scl = 1; sda = 1; enable = 0;
        scl_b = 1; sda_b = 1; en_b = 0;
        reset_n = 1;
        #2 reset_n = 0;
        #1;
        check("reset data_out", data_out, 0);
        check("reset byte_valid", byte_valid, 0);
        check("reset byte_index", byte_index, 0);
        check("reset finish", finish, 0);
        check("reset error", error, 0);
        check("reset sda_low", sda_low, 0);
        check("reset b data_out", data_out_b, 0);
        #20 reset_n = 1;
        @(posedge clock); #1;
        cmp_on = 1;

        // Frame 1: 0xA5, 0x3C
        bv_idx_q.delete(); fin_count = 0;
        send_frame(8'hA5, 8'h3C, -1);
        check("frame1 data_out", data_out, 16'hA53C);
        check("frame1 byte_valid count", bv_idx_q.size(), 2);
        if (bv_idx_q.size() == 2) begin
            check("frame1 first index", bv_idx_q[0], 0);
            check("frame1 second index", bv_idx_q[1], 1);
        end
        check("frame1 finish count", fin_count, 1);

        // Frame 2: STOP after 4 bits of word 1
        bv_idx_q.delete(); fin_count = 0;
        send_word(0, 8'h5A, 1'b1, -1);
        for (int i = DW-1; i >= DW-4; i--)
            bit_slot(i < 6 ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'hC3);
        low_first(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);           // SDA rises with SCL high: STOP
        m_err = 1'b1; m_sda_low = 1'b0; fall_act = FA_NONE;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("stop error", error, 1);
        check("stop data_out", data_out, 16'h5A3C);
        check("stop byte_valid count", bv_idx_q.size(), 1);
        check("stop finish count", fin_count, 0);

        // enable with SCL low in IDLE: ignored, error stays set
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("ignored enable error", error, 1);

        // Frame 3: clears error; stray enable on bit 4 of word 0 ignored
        bv_idx_q.delete(); fin_count = 0;
        send_frame(8'h96, 8'h0F, 4);
        check("frame3 data_out", data_out, 16'h960F);
        check("frame3 error cleared", error, 0);
        check("frame3 byte_valid count", bv_idx_q.size(), 2);

        // Reset in the middle of word 0
        bit_slot(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'hE1);
        bit_slot(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hE1);
        bit_slot(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hE1);
        reset_n = 0;
        m_data = '0; m_err = 0; m_sda_low = 0; m_bv = 0; m_fin = 0; fall_act = FA_NONE;
        #1;
        check("midreset data_out", data_out, 0);
        check("midreset byte_valid", byte_valid, 0);
        check("midreset finish", finish, 0);
        check("midreset sda_low", sda_low, 0);
        #2 reset_n = 1;
        @(posedge clock); #1;
        bv_idx_q.delete(); fin_count = 0;
        send_frame(8'hA5, 8'h3C, -1);
        check("post-reset data_out", data_out, 16'hA53C);
        check("post-reset finish count", fin_count, 1);

        // Single-bit, single-word instance
        cycb(1'b0, 1'b1, 1'b0);
        cycb(1'b0, 1'b1, 1'b0);
        cycb(1'b1, 1'b1, 1'b1);
        check("b byte_valid", byte_valid_b, 1);
        check("b data_out", data_out_b, 1);
        check("b byte_index", byte_index_b, 0);
        check("b finish early", finish_b, 0);
        cycb(1'b1, 1'b1, 1'b0);
        check("b byte_valid drop", byte_valid_b, 0);
        cycb(1'b0, 1'b0, 1'b0);
        check("b sda_low enter", sda_low_b, ACK_ON);
        cycb(1'b0, 1'b0, 1'b0);
        cycb(1'b1, 1'b0, 1'b0);
        cycb(1'b1, 1'b0, 1'b0);
        check("b sda_low hold", sda_low_b, ACK_ON);
        check("b finish before fall", finish_b, 0);
        cycb(1'b0, 1'b1, 1'b0);
        check("b finish", finish_b, 1);
        check("b sda_low leave", sda_low_b, 0);
        cycb(1'b0, 1'b1, 1'b0);
        check("b finish drop", finish_b, 0);
        check("b data_out hold", data_out_b, 1);
        check("b error", error_b, 0);

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
